// File: rtl/z_core_alu_seq_if.sv
//------------------------------------------------------------------------------
// z_core_alu_seq_if
// Request/result handshake bundle for the Z-Core sequential execute unit.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface z_core_alu_seq_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      in_op;
   logic [XLEN-1:0] in_a;
   logic [XLEN-1:0] in_b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_result;
   logic            out_taken;
   logic            out_zero;

   modport master (
      output in_valid, in_op, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_result, out_taken, out_zero
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, out_ready,
      output in_ready, out_valid, out_result, out_taken, out_zero
   );
endinterface

`default_nettype wire

// File: rtl/z_core_alu_seq.sv
//------------------------------------------------------------------------------
// z_core_alu_seq
// Sequential execute unit: single-cycle ALU/branch ops, bit-serial shifts.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module z_core_alu_seq #(
   parameter int XLEN = 32
) (
   input  wire logic          clk,
   input  wire logic          rstn,
   z_core_alu_seq_if.slave    bus
);

   localparam int              c_SHW      = $clog2(XLEN);
   localparam logic [c_SHW-1:0] c_CNT_ONE = {{(c_SHW-1){1'b0}}, 1'b1};
   localparam logic [c_SHW-1:0] c_CNT_ZERO = '0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           r_state;
   logic [XLEN-1:0]  r_result;
   logic             r_taken;
   logic [c_SHW-1:0] r_cnt;
   logic             r_sll;
   logic             r_sra;

   logic [XLEN-1:0]  w_alu;
   logic             w_taken;
   logic             w_lt;
   logic             w_ltu;
   logic             w_eq;
   logic             w_is_shift;
   logic [c_SHW-1:0] w_shamt;

   assign w_lt       = $signed(bus.in_a) < $signed(bus.in_b);
   assign w_ltu      = bus.in_a < bus.in_b;
   assign w_eq       = bus.in_a == bus.in_b;
   assign w_is_shift = (bus.in_op == 4'd2) || (bus.in_op == 4'd6) || (bus.in_op == 4'd7);
   assign w_shamt    = bus.in_b[c_SHW-1:0];

   // Result of every non-shift op, evaluated straight off the request pins at accept.
   always_comb begin
      w_alu   = '0;
      w_taken = 1'b0;
      case (bus.in_op)
         4'd0:    w_alu = bus.in_a + bus.in_b;
         4'd1:    w_alu = bus.in_a - bus.in_b;
         4'd3:    w_alu = {{(XLEN-1){1'b0}}, w_lt};
         4'd4:    w_alu = {{(XLEN-1){1'b0}}, w_ltu};
         4'd5:    w_alu = bus.in_a ^ bus.in_b;
         4'd8:    w_alu = bus.in_a | bus.in_b;
         4'd9:    w_alu = bus.in_a & bus.in_b;
         4'd10:   w_taken = w_eq;
         4'd11:   w_taken = ~w_eq;
         4'd12:   w_taken = w_lt;
         4'd13:   w_taken = ~w_lt;
         4'd14:   w_taken = w_ltu;
         4'd15:   w_taken = ~w_ltu;
         default: w_alu = bus.in_a;
      endcase
      if (bus.in_op >= 4'd10) begin
         w_alu = {{(XLEN-1){1'b0}}, w_taken};
      end
   end

   // r_result doubles as the shift working register; it is only exposed once in DONE.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state  <= IDLE;
         r_result <= '0;
         r_taken  <= 1'b0;
         r_cnt    <= '0;
         r_sll    <= 1'b0;
         r_sra    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  if (w_is_shift) begin
                     r_result <= bus.in_a;
                     r_taken  <= 1'b0;
                     r_cnt    <= w_shamt;
                     r_sll    <= (bus.in_op == 4'd2);
                     r_sra    <= (bus.in_op == 4'd7);
                     r_state  <= (w_shamt == c_CNT_ZERO) ? DONE : SHIFT;
                  end else begin
                     r_result <= w_alu;
                     r_taken  <= w_taken;
                     r_state  <= DONE;
                  end
               end
            end
            SHIFT: begin
               if (r_sll) begin
                  r_result <= {r_result[XLEN-2:0], 1'b0};
               end else begin
                  r_result <= {(r_sra & r_result[XLEN-1]), r_result[XLEN-1:1]};
               end
               r_cnt <= r_cnt - c_CNT_ONE;
               if (r_cnt == c_CNT_ONE) begin
                  r_state <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready   = (r_state == IDLE);
   assign bus.out_valid  = (r_state == DONE);
   assign bus.out_result = r_result;
   assign bus.out_taken  = r_taken;
   assign bus.out_zero   = (r_result == '0);

endmodule

`default_nettype wire

// File: tb/tb_z_core_alu_seq.sv
//------------------------------------------------------------------------------
// tb_z_core_alu_seq
// Self-checking bench: directed cases plus random ops against a reference model.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_z_core_alu_seq;

   localparam int XLEN = 32;

   logic clk;
   logic rstn;
   int   n_checks;
   int   n_errors;
   time  last_acc;

   z_core_alu_seq_if #(.XLEN(XLEN)) bus ();

   z_core_alu_seq #(.XLEN(XLEN)) u_dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic void ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic t);
      int sh;
      sh = int'(b[4:0]);
      t  = 1'b0;
      r  = '0;
      case (op)
         4'd0:  r = a + b;
         4'd1:  r = a - b;
         4'd2:  r = a << sh;
         4'd3:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd4:  r = (a < b) ? 32'd1 : 32'd0;
         4'd5:  r = a ^ b;
         4'd6:  r = a >> sh;
         4'd7:  r = $signed(a) >>> sh;
         4'd8:  r = a | b;
         4'd9:  r = a & b;
         4'd10: t = (a == b);
         4'd11: t = (a != b);
         4'd12: t = ($signed(a) < $signed(b));
         4'd13: t = ($signed(a) >= $signed(b));
         4'd14: t = (a < b);
         default: t = (a >= b);
      endcase
      if (op >= 4'd10) r = {31'd0, t};
   endfunction

   // Enter and leave at a falling edge with the unit expected idle.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int stall, input bit chk_ii);
      logic [31:0] er;
      logic        et;
      int          exp_lat;
      int          lat;
      bit          seen;
      ref_alu(op, a, b, er, et);
      exp_lat = (op == 4'd2 || op == 4'd6 || op == 4'd7) ? 1 + int'(b[4:0]) : 1;
      check("in_ready_idle", {31'd0, bus.in_ready}, 32'd1);
      bus.in_valid  = 1'b1;
      bus.in_op     = op;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.out_ready = (stall == 0);
      @(posedge clk);
      if (chk_ii) check("accept_spacing", 32'($time - last_acc), 32'd20);
      last_acc = $time;
      lat  = 0;
      seen = 1'b0;
      while (!seen && lat < 64) begin
         @(negedge clk);
         lat++;
         bus.in_valid = 1'b0;
         bus.in_op    = 4'($urandom);
         bus.in_a     = $urandom;
         bus.in_b     = $urandom;
         if (bus.out_valid) seen = 1'b1;
         else @(posedge clk);
      end
      check("out_valid_seen", {31'd0, seen}, 32'd1);
      check("latency", lat, exp_lat);
      check("result", bus.out_result, er);
      check("taken", {31'd0, bus.out_taken}, {31'd0, et});
      check("zero", {31'd0, bus.out_zero}, {31'd0, (er == 32'd0)});
      check("in_ready_done", {31'd0, bus.in_ready}, 32'd0);
      for (int i = 0; i < stall; i++) begin
         bus.in_valid = 1'b1;
         bus.in_op    = 4'($urandom);
         bus.in_a     = $urandom;
         bus.in_b     = $urandom;
         @(posedge clk);
         @(negedge clk);
         check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
         check("stall_result", bus.out_result, er);
         check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("valid_drop", {31'd0, bus.out_valid}, 32'd0);
   endtask

   initial begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      n_checks      = 0;
      n_errors      = 0;
      last_acc      = 0;
      rstn          = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_op     = '0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_result", bus.out_result, 32'd0);
      check("rst_taken", {31'd0, bus.out_taken}, 32'd0);
      check("rst_zero", {31'd0, bus.out_zero}, 32'd1);
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      rstn = 1'b1;
      @(negedge clk);

      // Single-cycle ALU ops
      run_op(4'd0, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
      run_op(4'd1, 32'd5, 32'd7, 0, 1'b0);
      run_op(4'd3, 32'h8000_0000, 32'd1, 0, 1'b0);
      run_op(4'd4, 32'h8000_0000, 32'd1, 0, 1'b0);
      // Shifts, including the longest and zero-amount cases
      run_op(4'd7, 32'h8000_0000, 32'd31, 0, 1'b0);
      run_op(4'd6, 32'h8000_0000, 32'd31, 0, 1'b0);
      run_op(4'd2, 32'h0000_0001, 32'h25, 0, 1'b0);
      run_op(4'd2, 32'h1234_5678, 32'h20, 0, 1'b0);
      run_op(4'd7, 32'h8765_4321, 32'h0, 0, 1'b0);
      // Branches
      run_op(4'd12, 32'hFFFF_FFFF, 32'd0, 0, 1'b0);
      run_op(4'd14, 32'hFFFF_FFFF, 32'd0, 0, 1'b0);
      run_op(4'd10, 32'd7, 32'd7, 0, 1'b0);
      run_op(4'd15, 32'd0, 32'd0, 0, 1'b0);
      // Back-pressure with a noisy request side
      run_op(4'd5, 32'hF0F0_F0F0, 32'hFFFF_0000, 10, 1'b0);
      // Back-to-back ADDs
      run_op(4'd0, 32'd1, 32'd2, 0, 1'b0);
      run_op(4'd0, 32'd3, 32'd4, 0, 1'b1);
      run_op(4'd0, 32'd5, 32'd6, 0, 1'b1);

      // Reset in the middle of a long shift
      bus.in_valid  = 1'b1;
      bus.in_op     = 4'd2;
      bus.in_a      = $urandom | 32'd1;
      bus.in_b      = 32'd20;
      bus.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
      check("mid_rst_result", bus.out_result, 32'd0);
      check("mid_rst_zero", {31'd0, bus.out_zero}, 32'd1);
      check("mid_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check("post_rst_valid", {31'd0, bus.out_valid}, 32'd0);
      run_op(4'd9, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 0, 1'b0);

      // Randomized traffic
      for (int n = 0; n < 60; n++) begin
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 3) == 0) b = a;
         run_op(op, a, b, ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
